// File: rtl/matrix_result_streamer.sv
// -----------------------------------------------------------------------------
// matrix_result_streamer
//
// Takes a snapshot of a square result matrix on a capture request and streams
// it out one element per transfer, row-major, over a valid/ready handshake.
// The FSM walks IDLE -> STREAM -> DONE -> IDLE.
//
// Ports
//   clock_signal     in   rising-edge clock for all state
//   reset_signal     in   synchronous active-high reset
//   capture_request  in   pulse: snapshot matrix_input and start a stream
//   matrix_input     in   [MATRIX_SIZE][MATRIX_SIZE] x DATA_WIDTH matrix
//   stream_data      out  element at [stream_row][stream_col] of the snapshot
//   stream_row       out  row index of stream_data
//   stream_col       out  column index of stream_data
//   stream_valid     out  element/indices valid (high exactly in STREAM)
//   stream_ready     in   sink accepts the current element
//   stream_last      out  current element is the bottom-right one
//   streamer_busy    out  high in STREAM and DONE
//   stream_done      out  one-cycle pulse after the final transfer
//   capture_dropped  out  one-cycle pulse when a capture request is ignored
//
// All outputs are registers. Each output register is loaded from the value
// that the corresponding signal must have in the state being entered, so the
// outputs line up with the state register without any combinational decode.
// -----------------------------------------------------------------------------
module matrix_result_streamer #(
    parameter int MATRIX_SIZE = 4,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                           clock_signal,
    input  logic                           reset_signal,
    input  logic                           capture_request,
    input  logic [DATA_WIDTH-1:0]          matrix_input [MATRIX_SIZE][MATRIX_SIZE],
    output logic [DATA_WIDTH-1:0]          stream_data,
    output logic [$clog2(MATRIX_SIZE)-1:0] stream_row,
    output logic [$clog2(MATRIX_SIZE)-1:0] stream_col,
    output logic                           stream_valid,
    input  logic                           stream_ready,
    output logic                           stream_last,
    output logic                           streamer_busy,
    output logic                           stream_done,
    output logic                           capture_dropped
);

    localparam int                IDX_W   = $clog2(MATRIX_SIZE);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(MATRIX_SIZE - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;

    logic [IDX_W-1:0]        row_r;
    logic [IDX_W-1:0]        col_r;
    logic [IDX_W-1:0]        row_next_s;
    logic [IDX_W-1:0]        col_next_s;

    logic [DATA_WIDTH-1:0]   snapshot_r      [MATRIX_SIZE][MATRIX_SIZE];
    logic [DATA_WIDTH-1:0]   snapshot_next_s [MATRIX_SIZE][MATRIX_SIZE];

    logic                    accept_s;
    logic                    xfer_s;
    logic                    at_last_s;

    logic [DATA_WIDTH-1:0]   data_next_s;
    logic                    valid_next_s;
    logic                    last_next_s;
    logic                    busy_next_s;
    logic                    done_next_s;
    logic                    dropped_next_s;

    logic [DATA_WIDTH-1:0]   data_r;
    logic                    valid_r;
    logic                    last_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    dropped_r;

    // Handshake qualifiers shared by the next-state and datapath logic.
    always_comb begin
        accept_s  = (state_r == ST_IDLE) && capture_request;
        xfer_s    = valid_r && stream_ready;
        at_last_s = (row_r == IDX_MAX) && (col_r == IDX_MAX);
    end

    // State register plus index and snapshot storage.
    always_ff @(posedge clock_signal) begin
        if (reset_signal) begin
            state_r <= ST_IDLE;
            row_r   <= '0;
            col_r   <= '0;
            for (int r = 0; r < MATRIX_SIZE; r++) begin
                for (int c = 0; c < MATRIX_SIZE; c++) begin
                    snapshot_r[r][c] <= '0;
                end
            end
        end else begin
            state_r <= next_state_s;
            row_r   <= row_next_s;
            col_r   <= col_next_s;
            for (int r = 0; r < MATRIX_SIZE; r++) begin
                for (int c = 0; c < MATRIX_SIZE; c++) begin
                    snapshot_r[r][c] <= snapshot_next_s[r][c];
                end
            end
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_STREAM;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (xfer_s && at_last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_STREAM;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Row-major index walk; the snapshot only loads on an accepted capture,
    // so requests during STREAM/DONE and later input changes cannot disturb it.
    always_comb begin
        row_next_s = row_r;
        col_next_s = col_r;
        for (int r = 0; r < MATRIX_SIZE; r++) begin
            for (int c = 0; c < MATRIX_SIZE; c++) begin
                snapshot_next_s[r][c] = snapshot_r[r][c];
            end
        end

        if (accept_s) begin
            row_next_s = '0;
            col_next_s = '0;
            for (int r = 0; r < MATRIX_SIZE; r++) begin
                for (int c = 0; c < MATRIX_SIZE; c++) begin
                    snapshot_next_s[r][c] = matrix_input[r][c];
                end
            end
        end else if (xfer_s) begin
            if (at_last_s) begin
                row_next_s = '0;
                col_next_s = '0;
            end else if (col_r == IDX_MAX) begin
                row_next_s = row_r + IDX_ONE;
                col_next_s = '0;
            end else begin
                row_next_s = row_r;
                col_next_s = col_r + IDX_ONE;
            end
        end else begin
            row_next_s = row_r;
            col_next_s = col_r;
        end
    end

    // Output decode for the state being entered; registered below.
    always_comb begin
        valid_next_s   = (next_state_s == ST_STREAM);
        busy_next_s    = (next_state_s != ST_IDLE);
        done_next_s    = (next_state_s == ST_DONE);
        last_next_s    = (next_state_s == ST_STREAM) &&
                         (row_next_s == IDX_MAX) && (col_next_s == IDX_MAX);
        dropped_next_s = capture_request && (state_r != ST_IDLE);
        data_next_s    = snapshot_next_s[row_next_s][col_next_s];
    end

    // Output registers.
    always_ff @(posedge clock_signal) begin
        if (reset_signal) begin
            data_r    <= '0;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dropped_r <= 1'b0;
        end else begin
            data_r    <= data_next_s;
            valid_r   <= valid_next_s;
            last_r    <= last_next_s;
            busy_r    <= busy_next_s;
            done_r    <= done_next_s;
            dropped_r <= dropped_next_s;
        end
    end

    assign stream_data     = data_r;
    assign stream_row      = row_r;
    assign stream_col      = col_r;
    assign stream_valid    = valid_r;
    assign stream_last     = last_r;
    assign streamer_busy   = busy_r;
    assign stream_done     = done_r;
    assign capture_dropped = dropped_r;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// -----------------------------------------------------------------------------
// Bench for matrix_result_streamer (MATRIX_SIZE=4, DATA_WIDTH=8).
// A queue model holds the beats still owed by the current stream; every
// negedge the DUT outputs are compared against it. Directed tests add
// hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_matrix_result_streamer;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          cap;
    logic [DW-1:0] mat [N][N];
    logic [DW-1:0] stream_data;
    logic [1:0]    stream_row;
    logic [1:0]    stream_col;
    logic          stream_valid;
    logic          ready;
    logic          stream_last;
    logic          streamer_busy;
    logic          stream_done;
    logic          capture_dropped;

    matrix_result_streamer #(.MATRIX_SIZE(N), .DATA_WIDTH(DW)) dut (
        .clock_signal    (clk),
        .reset_signal    (rst),
        .capture_request (cap),
        .matrix_input    (mat),
        .stream_data     (stream_data),
        .stream_row      (stream_row),
        .stream_col      (stream_col),
        .stream_valid    (stream_valid),
        .stream_ready    (ready),
        .stream_last     (stream_last),
        .streamer_busy   (streamer_busy),
        .stream_done     (stream_done),
        .capture_dropped (capture_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors   = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [1:0]    r;
        logic [1:0]    c;
        logic [DW-1:0] v;
    } beat_t;

    beat_t q[$];
    int    m_phase;       // 0 idle, 1 streaming, 2 done
    logic  m_dropped;
    logic  chk_en;
    int    dut_beats;     // DUT-observed transfers
    int    ff_beats;      // DUT-observed transfers carrying 8'hFF
    int    drops;         // DUT-observed capture_dropped pulses

    initial begin
        m_phase   = 0;
        m_dropped = 1'b0;
        dut_beats = 0;
        ff_beats  = 0;
        drops     = 0;
    end

    always @(posedge clk) begin
        if (stream_valid === 1'b1 && ready === 1'b1) begin
            dut_beats++;
            if (stream_data === 8'hFF) ff_beats++;
        end
        if (capture_dropped === 1'b1) drops++;

        if (rst) begin
            q.delete();
            m_phase   = 0;
            m_dropped = 1'b0;
        end else begin
            m_dropped = cap && (m_phase != 0);
            case (m_phase)
                0: if (cap) begin
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++)
                            q.push_back('{r: 2'(r), c: 2'(c), v: mat[r][c]});
                    m_phase = 1;
                end
                1: if (ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", stream_valid, (m_phase == 1) ? 1 : 0);
            chk("busy", streamer_busy, (m_phase != 0) ? 1 : 0);
            chk("done", stream_done, (m_phase == 2) ? 1 : 0);
            chk("dropped", capture_dropped, m_dropped);
            if (m_phase == 1 && q.size() > 0) begin
                chk("data", stream_data, q[0].v);
                chk("row", stream_row, q[0].r);
                chk("col", stream_col, q[0].c);
                chk("last", stream_last, (q.size() == 1) ? 1 : 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_pattern(input int mode);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                case (mode)
                    0:       mat[r][c] = 8'(r * 4 + c + 1 + (r + c) * 2);
                    1:       mat[r][c] = 8'h55;
                    default: mat[r][c] = 8'hFF;
                endcase
    endtask

    task automatic capture();
        cap = 1'b1;
        tick();
        cap = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 100 && stream_done !== 1'b1; k++) tick();
        chk("wait_done", stream_done, 1);
    endtask

    int n;
    int base_beats;
    int base_ff;
    int base_drops;

    initial begin
        chk_en = 1'b0;
        rst    = 1'b1;
        cap    = 1'b0;
        ready  = 1'b0;
        set_pattern(0);
        tick();
        chk_en = 1'b1;
        tick();

        // Reset state
        chk("rst_valid", stream_valid, 0);
        chk("rst_busy", streamer_busy, 0);
        chk("rst_done", stream_done, 0);
        chk("rst_drop", capture_dropped, 0);
        chk("rst_last", stream_last, 0);
        chk("rst_data", stream_data, 0);
        chk("rst_row", stream_row, 0);
        chk("rst_col", stream_col, 0);
        rst = 1'b0;
        tick();

        // T1: full stream with ready high, latency 17
        ready = 1'b1;
        base_beats = dut_beats;
        capture();
        for (n = 1; n <= 40; n++) begin
            if (n == 1)  begin chk("t1_d00", stream_data, 1); chk("t1_r00", stream_row, 0); chk("t1_c00", stream_col, 0); end
            if (n == 2)  chk("t1_d01", stream_data, 4);
            if (n == 5)  begin chk("t1_d10", stream_data, 7); chk("t1_r10", stream_row, 1); chk("t1_c10", stream_col, 0); end
            if (n == 16) begin chk("t1_d33", stream_data, 28); chk("t1_last", stream_last, 1); end
            if (stream_done === 1'b1) break;
            tick();
        end
        chk("t1_latency", n, 17);
        chk("t1_beats", dut_beats - base_beats, 16);

        // T2: back-to-back capture, stall 3 cycles on [1][1]
        tick();
        chk("t2_idle_gap", streamer_busy, 0);
        base_beats = dut_beats;
        capture();
        repeat (5) tick();
        ready = 1'b0;
        repeat (3) begin
            chk("t2_stall_data", stream_data, 10);
            chk("t2_stall_row", stream_row, 1);
            chk("t2_stall_col", stream_col, 1);
            tick();
        end
        ready = 1'b1;
        wait_done();
        chk("t2_beats", dut_beats - base_beats, 16);

        // T3: second capture mid-stream is dropped
        tick();
        base_beats = dut_beats;
        base_drops = drops;
        capture();
        repeat (4) tick();
        set_pattern(1);
        capture();
        chk("t3_drop_pulse", capture_dropped, 1);
        tick();
        chk("t3_drop_clear", capture_dropped, 0);
        wait_done();
        chk("t3_drops", drops - base_drops, 1);
        chk("t3_beats", dut_beats - base_beats, 16);

        // T4: input overwritten after capture
        tick();
        set_pattern(0);
        base_ff = ff_beats;
        capture();
        set_pattern(2);
        wait_done();
        chk("t4_no_ff", ff_beats - base_ff, 0);

        // T5: reset at beat 8 aborts, fresh capture restarts
        tick();
        set_pattern(0);
        capture();
        repeat (8) tick();
        chk("t5_beat8", stream_data, 8'(2 * 4 + 0 + 1 + 2 * 2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid", stream_valid, 0);
        chk("t5_busy", streamer_busy, 0);
        chk("t5_data", stream_data, 0);
        repeat (3) begin
            tick();
            chk("t5_no_done", stream_done, 0);
        end
        capture();
        chk("t5_restart_d", stream_data, 1);
        chk("t5_restart_r", stream_row, 0);
        chk("t5_restart_c", stream_col, 0);
        wait_done();

        // T6: capture right after done with all-0xFF matrix
        tick();
        chk("t6_idle", streamer_busy, 0);
        set_pattern(2);
        base_ff = ff_beats;
        capture();
        chk("t6_first", stream_data, 255);
        wait_done();
        chk("t6_ff_beats", ff_beats - base_ff, 16);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
